// File: rtl/nios_debug_action_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_debug_action_sequencer_pkg
// Purpose  : Shared command encoding, strobe priority and default sizing
// Revision : 1.0
// ============================================================================
package nios_debug_action_sequencer_pkg;

    localparam int unsigned DEFAULT_FIFO_DEPTH     = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned NUM_ACTIONS            = 6;
    localparam int unsigned CMD_W                  = 3;
    localparam int unsigned JDO_W                  = 38;
    localparam int unsigned ENTRY_W                = CMD_W + JDO_W;
    localparam int unsigned WAIT_W                 = 16;

    typedef enum logic [CMD_W-1:0] {
        CMD_OCIMEM_A  = 3'd0,
        CMD_OCIMEM_B  = 3'd1,
        CMD_BREAK_A   = 3'd2,
        CMD_BREAK_B   = 3'd3,
        CMD_BREAK_C   = 3'd4,
        CMD_TRACECTRL = 3'd5
    } cmd_type_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Bit i of the strobe vector carries command code i; lower index wins.
    function automatic cmd_type_e prio_encode(input logic [NUM_ACTIONS-1:0] strobes);
        if (strobes[0])      return CMD_OCIMEM_A;
        else if (strobes[1]) return CMD_OCIMEM_B;
        else if (strobes[2]) return CMD_BREAK_A;
        else if (strobes[3]) return CMD_BREAK_B;
        else if (strobes[4]) return CMD_BREAK_C;
        else                 return CMD_TRACECTRL;
    endfunction

    function automatic logic multi_hot(input logic [NUM_ACTIONS-1:0] strobes);
        return (strobes & (strobes - NUM_ACTIONS'(1))) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios_debug_action_fifo.sv
`default_nettype none
// ============================================================================
// Module   : nios_debug_action_fifo
// Purpose  : Synchronous action FIFO with a registered head word
// Revision : 1.0
// ============================================================================
module nios_debug_action_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;
    assign head  = head_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_W'(1);
        end
        // Head register tracks the post-update array so a fresh push is visible next cycle.
        head_d = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios_debug_action_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nios_debug_action_sequencer
// Purpose  : Queues debug action strobes and issues them as acked commands
// Revision : 1.0
// ============================================================================
module nios_debug_action_sequencer
    import nios_debug_action_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          take_action_ocimem_a,
    input  logic                          take_action_ocimem_b,
    input  logic                          take_action_break_a,
    input  logic                          take_action_break_b,
    input  logic                          take_action_break_c,
    input  logic                          take_action_tracectrl,
    input  logic [JDO_W-1:0]              jdo,
    output logic                          cmd_valid,
    output logic [CMD_W-1:0]              cmd_type,
    output logic [JDO_W-1:0]              cmd_jdo,
    input  logic                          cmd_ack,
    input  logic                          err_clr,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_err,
    output logic                          ovf_err,
    output logic                          timeout_err
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_ACTIONS-1:0] strobes;
    logic                   any_strobe;
    logic [ENTRY_W-1:0]     push_data;
    logic [ENTRY_W-1:0]     head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   drop_q, drop_d;
    logic                   ovf_q, ovf_d;
    logic                   tmo_q, tmo_d;
    logic                   timeout_evt;

    assign strobes    = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                         take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};
    assign any_strobe = |strobes;
    assign push_data  = {prio_encode(strobes), jdo};

    nios_debug_action_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (any_strobe),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pop         = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                    wait_d  = '0;
                end
            end
            ST_ISSUE: begin
                // An ack in the final wait cycle takes precedence over the timeout.
                if (cmd_ack) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    pop         = 1'b1;
                    timeout_evt = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        drop_d = (drop_q && !err_clr) || multi_hot(strobes);
        ovf_d  = (ovf_q  && !err_clr) || (any_strobe && fifo_full && !pop);
        tmo_d  = (tmo_q  && !err_clr) || timeout_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_valid   = (state_q == ST_ISSUE);
    assign cmd_type    = cmd_valid ? head[ENTRY_W-1:JDO_W] : '0;
    assign cmd_jdo     = cmd_valid ? head[JDO_W-1:0] : '0;
    assign busy        = !fifo_empty || (state_q != ST_IDLE);
    assign drop_err    = drop_q;
    assign ovf_err     = ovf_q;
    assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_debug_action_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_debug_action_sequencer
// Purpose  : Self-checking bench: vector table, scoreboard and corner sequences
// Revision : 1.0
// ============================================================================
module tb_nios_debug_action_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  strobes = '0;
    logic [37:0] jdo = '0;
    logic        cmd_ack = 1'b0;
    logic        err_clr = 1'b0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [37:0] cmd_jdo;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        drop_err, ovf_err, timeout_err;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    logic [40:0] sb [$];

    typedef struct {
        logic [5:0]  s;
        logic [37:0] jdo;
        logic [2:0]  typ;
        logic        drop;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    nios_debug_action_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .take_action_ocimem_a  (strobes[0]),
        .take_action_ocimem_b  (strobes[1]),
        .take_action_break_a   (strobes[2]),
        .take_action_break_b   (strobes[3]),
        .take_action_break_c   (strobes[4]),
        .take_action_tracectrl (strobes[5]),
        .jdo                   (jdo),
        .cmd_valid             (cmd_valid),
        .cmd_type              (cmd_type),
        .cmd_jdo               (cmd_jdo),
        .cmd_ack               (cmd_ack),
        .err_clr               (err_clr),
        .busy                  (busy),
        .fifo_level            (fifo_level),
        .drop_err              (drop_err),
        .ovf_err               (ovf_err),
        .timeout_err           (timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] model_type(input logic [5:0] s);
        logic [2:0] t = 3'd0;
        for (int i = 5; i >= 0; i--) if (s[i]) t = 3'(i);
        return t;
    endfunction

    task automatic do_strobe(input logic [5:0] s, input logic [37:0] d, input bit expect_cmd);
        strobes = s;
        jdo     = d;
        if (expect_cmd) sb.push_back({model_type(s), d});
        tick();
        strobes = '0;
        jdo     = '0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Scoreboard: every accepted command must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ack) begin
            n_acc++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_cmd actual type=%0d jdo=%0h required none", cmd_type, cmd_jdo);
            end else begin
                logic [40:0] e;
                e = sb.pop_front();
                chk("sb_cmd_type", 64'(cmd_type), 64'(e[40:38]));
                chk("sb_cmd_jdo", 64'(cmd_jdo), 64'(e[37:0]));
            end
        end
    end

    initial begin
        int peak, k, cnt, acc0;

        vecs[0] = '{6'b000001, 38'h00_0000_0001, 3'd0, 1'b0};
        vecs[1] = '{6'b000010, 38'h3F_FFFF_FFFF, 3'd1, 1'b0};
        vecs[2] = '{6'b000100, 38'h12_3456_789A, 3'd2, 1'b0};
        vecs[3] = '{6'b001000, 38'h15_DEAD_BEEF, 3'd3, 1'b0};
        vecs[4] = '{6'b010000, 38'h2A_5555_AAAA, 3'd4, 1'b0};
        vecs[5] = '{6'b100000, 38'h01_CAFE_F00D, 3'd5, 1'b0};
        vecs[6] = '{6'b100001, 38'h0A_0000_0005, 3'd0, 1'b1};
        vecs[7] = '{6'b010100, 38'h0B_0000_0006, 3'd2, 1'b1};
        vecs[8] = '{6'b111110, 38'h0C_0000_0007, 3'd1, 1'b1};
        vecs[9] = '{6'b110000, 38'h0D_0000_0008, 3'd4, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_type", 64'(cmd_type), 64'd0);
        chk("rst_cmd_jdo", 64'(cmd_jdo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_errs", 64'({drop_err, ovf_err, timeout_err}), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single break_b with ack held high: latency and pulse width
        cmd_ack = 1'b1;
        do_strobe(6'b001000, 38'h15_DEAD_BEEF, 1'b1);
        chk("t1_valid_n1", 64'(cmd_valid), 64'd0);
        tick();
        chk("t1_valid_n2", 64'(cmd_valid), 64'd1);
        chk("t1_type_n2", 64'(cmd_type), 64'd3);
        chk("t1_jdo_n2", 64'(cmd_jdo), 64'h15_DEAD_BEEF);
        tick();
        chk("t1_valid_n3", 64'(cmd_valid), 64'd0);
        tick();
        chk("t1_busy_n4", 64'(busy), 64'd0);

        // Vector table: priority encoding and drop detection
        foreach (vecs[i]) begin
            pulse_clr();
            do_strobe(vecs[i].s, vecs[i].jdo, 1'b1);
            peak = int'(fifo_level);
            k = 0;
            while (!cmd_valid && k < 8) begin
                tick();
                if (int'(fifo_level) > peak) peak = int'(fifo_level);
                k++;
            end
            chk("vec_valid_seen", 64'(cmd_valid), 64'd1);
            chk("vec_type", 64'(cmd_type), 64'(vecs[i].typ));
            chk("vec_drop", 64'(drop_err), 64'(vecs[i].drop));
            chk("vec_level_peak", 64'(peak), 64'd1);
            wait_idle("vec_idle");
        end

        // Overflow: five strobes into a depth-4 FIFO with no ack
        pulse_clr();
        cmd_ack = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            do_strobe(6'(1 << i), 38'(64'h100 + i), i < 4);
        end
        chk("ovf_level", 64'(fifo_level), 64'd4);
        chk("ovf_flag", 64'(ovf_err), 64'd1);
        cmd_ack = 1'b1;
        wait_idle("ovf_idle");
        chk("ovf_acc_count", 64'(n_acc - acc0), 64'd4);
        chk("ovf_no_timeout", 64'(timeout_err), 64'd0);

        // Timeout: no ack ever
        pulse_clr();
        cmd_ack = 1'b0;
        do_strobe(6'b001000, 38'h22_0000_0022, 1'b0);
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            if (cmd_valid) cnt++;
            tick();
        end
        chk("tmo_valid_cycles", 64'(cnt), 64'd8);
        chk("tmo_flag", 64'(timeout_err), 64'd1);
        chk("tmo_level", 64'(fifo_level), 64'd0);
        chk("tmo_busy", 64'(busy), 64'd0);

        // Ack arriving in the exact timeout cycle wins
        pulse_clr();
        chk("clr_tmo", 64'(timeout_err), 64'd0);
        do_strobe(6'b000010, 38'h33_0000_0033, 1'b1);
        tick();
        chk("ackwin_valid_first", 64'(cmd_valid), 64'd1);
        repeat (7) tick();
        chk("ackwin_valid_last", 64'(cmd_valid), 64'd1);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        chk("ackwin_no_tmo", 64'(timeout_err), 64'd0);
        chk("ackwin_valid_after", 64'(cmd_valid), 64'd0);

        // err_clr coinciding with a fresh drop event keeps the flag set
        cmd_ack = 1'b1;
        do_strobe(6'b100001, 38'h0E_0000_0001, 1'b1);
        chk("drop_set", 64'(drop_err), 64'd1);
        err_clr = 1'b1;
        do_strobe(6'b001100, 38'h0E_0000_0002, 1'b1);
        err_clr = 1'b0;
        chk("drop_clr_collide", 64'(drop_err), 64'd1);
        pulse_clr();
        chk("drop_cleared", 64'(drop_err), 64'd0);
        wait_idle("drop_idle");

        // Reset in the middle of ISSUE with three entries queued
        cmd_ack = 1'b0;
        do_strobe(6'b100000, 38'h01, 1'b0);
        do_strobe(6'b010000, 38'h02, 1'b0);
        do_strobe(6'b001000, 38'h03, 1'b0);
        chk("rmid_valid_pre", 64'(cmd_valid), 64'd1);
        chk("rmid_level_pre", 64'(fifo_level), 64'd3);
        reset_n = 1'b0;
        strobes = 6'b111111;
        jdo     = 38'h3F_0000_0000;
        #1;
        chk("rmid_outputs", 64'({cmd_valid, cmd_type, busy, fifo_level, drop_err, ovf_err, timeout_err}), 64'd0);
        chk("rmid_jdo", 64'(cmd_jdo), 64'd0);
        repeat (2) tick();
        strobes = '0;
        jdo     = '0;
        reset_n = 1'b1;
        cnt = 0;
        for (int j = 0; j < 10; j++) begin
            if (cmd_valid || busy) cnt++;
            tick();
        end
        chk("rmid_quiet_after", 64'(cnt), 64'd0);
        chk("rmid_errs_after", 64'({drop_err, ovf_err, timeout_err}), 64'd0);
        acc0 = n_acc;
        cmd_ack = 1'b1;
        do_strobe(6'b010000, 38'h2B_1234_5678, 1'b1);
        wait_idle("rmid_new_idle");
        chk("rmid_new_cmd", 64'(n_acc - acc0), 64'd1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_debug_action_sequencer.md
NIOS_DEBUG_ACTION_SEQUENCER -- requirements
Module: nios_debug_action_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of pending action entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles cmd_valid may wait for cmd_ack (range 2..65535).
REQ-003 SHALL have one clock; reset is asynchronous and active-low (ports clk, reset_n).
REQ-004 clk  in  1  system clock, all logic rising-edge.
REQ-005 reset_n  in  1  async active-low reset.
REQ-006 take_action_ocimem_a, take_action_ocimem_b, take_action_break_a, take_action_break_b, take_action_break_c, take_action_tracectrl  in  1 each  single-cycle action strobes from the debug slave sysclk domain.
REQ-007 jdo  in  38  JTAG data-out word, valid in the strobe cycle.
REQ-008 cmd_valid  out  1  command presented to the OCI/break-register logic.
REQ-009 cmd_type  out  3  command code: 0 OCIMEM_A, 1 OCIMEM_B, 2 BREAK_A, 3 BREAK_B, 4 BREAK_C, 5 TRACECTRL.
REQ-010 cmd_jdo  out  38  jdo captured with the command.
REQ-011 cmd_ack  in  1  consumer accepts the command in this cycle.
REQ-012 err_clr  in  1  clears all sticky error flags.
REQ-013 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-014 fifo_level  out  clog2(FIFO_DEPTH)+1  current entry count.
REQ-015 drop_err, ovf_err, timeout_err  out  1 each  sticky error flags.

Function
REQ-016 An asserted strobe SHALL push {type, jdo} in the same cycle; the entry is visible at the FIFO head at N+1.
REQ-017 When several strobes are high together, only the highest-priority one SHALL be pushed (order: ocimem_a > ocimem_b > break_a > break_b > break_c > tracectrl), and drop_err SHALL be set.
REQ-018 A push while full SHALL be accepted only if a pop happens in the same cycle; otherwise the entry is discarded, ovf_err is set, and the FIFO contents are unchanged.
REQ-019 The FSM states SHALL be IDLE and ISSUE.
REQ-020 IDLE: cmd_valid=0; if the FIFO is non-empty, go to ISSUE on the next edge.
REQ-021 Strobe at cycle N with the FIFO empty and the FSM in IDLE SHALL give cmd_valid=1 at N+2.
REQ-022 ISSUE: cmd_valid=1, with cmd_type and cmd_jdo equal to the FIFO head and held stable until it leaves ISSUE.
REQ-023 ISSUE with cmd_ack=1: pop the head and go to IDLE; back-to-back commands therefore have one idle cycle between them.
REQ-024 ISSUE: the wait counter SHALL be cleared on entry and incremented on each cycle without cmd_ack.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES-1 with no cmd_ack, the head SHALL be popped (discarded), timeout_err set, and the FSM go to IDLE.
REQ-026 If cmd_ack and the timeout coincide, cmd_ack SHALL win: normal pop, no timeout_err.
REQ-027 cmd_ack in IDLE SHALL be ignored.
REQ-028 Error flags SHALL be sticky; err_clr clears them next edge; set-event and err_clr in the same cycle SHALL leave the flag set.
REQ-029 fifo_level SHALL update the edge after push/pop; simultaneous push and pop leave it unchanged.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE, FIFO empty, wait counter 0, cmd_valid=0, cmd_type=0, cmd_jdo=0, busy=0, fifo_level=0, all error flags 0.
REQ-031 Reset mid-ISSUE SHALL abort the command with no pop reported and no error flagged; strobes during reset SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the cmd_type encoding, the priority order, and the FIFO_DEPTH/TIMEOUT_CYCLES defaults.
REQ-033 Storage SHALL be one sub-module, nios_debug_action_fifo (synchronous, 41-bit wide, registered head output, full/empty/level outputs).
REQ-034 Priority encode, FSM and timeout counter SHALL live in the top level.

Verification
REQ-035 Single take_action_break_b, jdo=38'h15_DEAD_BEEF, cmd_ack held high -> cmd_valid at N+2, cmd_type=3, cmd_jdo matches, 1-cycle pulse, busy low at N+4.
REQ-036 take_action_ocimem_a and take_action_tracectrl in the same cycle -> one command, type 0, drop_err=1, fifo_level peak 1.
REQ-037 cmd_ack low, 5 strobes with FIFO_DEPTH=4 -> fifo_level=4, ovf_err=1, fifth entry absent; acking all gives 4 commands in order.
REQ-038 TIMEOUT_CYCLES=8, cmd_ack never asserted -> cmd_valid high 8 cycles, then timeout_err=1, entry discarded, state IDLE.
REQ-039 cmd_ack in the exact timeout cycle -> no timeout_err; err_clr while drop_err is being re-set -> flag stays 1.
REQ-040 reset_n pulsed low during ISSUE with 3 queued entries -> all outputs 0 immediately; after release no cmd_valid until a new strobe arrives.
